diram_phy_responder: RTL and testbench
======================================

Name: diram_phy_responder

Overview:
- PHY/DRAM-side responder for the manager's DFI command/data interface, i.e. the far end of the manager's DRAM port.
- Decodes cs/cmd1/cmd0/bank/addr and tracks the open row per bank.
- Stores write data in a small internal array and returns read data with phy__dfi__valid after a fixed latency.
- Used per manager in system-level simulation and emulation in place of real DiRAM.

Parameters:
BANK_W, 5, bank address width (matches dfi__phy__bank)
ADDR_W, 12, phy address width (row on ACT, column on RD/WR)
DATA_W, 256, data bus width (dfi__phy__data / phy__dfi__data)
GRP_W, 8, number of clock/valid groups on the return path
ROW_IDX_W, 2, low row bits kept for array indexing
COL_IDX_W, 3, low column bits kept for array indexing
RL, 4, read latency in cycles, command cycle to valid (range 2..15)
WL, 2, write latency in cycles, command cycle to write-data capture (range 1..15)

Ports:
clk  in  1  block clock
reset_poweron  in  1  synchronous, active-low reset
dfi__phy__cs  in  1  command select, active high
dfi__phy__cmd1  in  1  command bit 1
dfi__phy__cmd0  in  1  command bit 0
dfi__phy__bank  in  BANK_W  bank address
dfi__phy__addr  in  ADDR_W  row (ACT) or column (RD/WR)
dfi__phy__data  in  DATA_W  write data, sampled WL cycles after WR
phy__dfi__valid  out  GRP_W  read data valid, all bits identical
phy__dfi__data  out  DATA_W  read data
err_pulse  out  1  one-cycle protocol-error strobe
err_count  out  16  saturating protocol-error counter

Behaviour:
- Single clock domain; all state registered on posedge clk.
- Reset: applies on any clk edge with reset_poweron==0. Clears the open-row table, RD/WR pipelines, outputs and err_count. Storage array is NOT cleared.
- Reset values of outputs: phy__dfi__valid=0, phy__dfi__data=0, err_pulse=0, err_count=0.
- Command decode: cs==0 -> NOP. With cs==1, {cmd1,cmd0}: 00 PRE, 01 ACT, 10 RD, 11 WR.
- Open-row table: per bank, open bit plus row[ROW_IDX_W-1:0].
  - ACT sets open and stores addr low bits.
  - PRE clears open.
- Array index: {bank, row_idx, addr[COL_IDX_W-1:0]}. Depth is 2^(BANK_W+ROW_IDX_W+COL_IDX_W).
- RD at cycle t:
  - Array is read at t.
  - Data and valid are presented at t+RL via an RL-deep shift pipeline; valid is all-ones for exactly 1 cycle per RD.
  - Back-to-back RDs yield back-to-back valids.
- WR at cycle t:
  - Index goes into a WL-deep pipeline.
  - dfi__phy__data is sampled at t+WL and written to the array that cycle.
- Ordering: an RD at cycle t returns array contents as of t. A WR whose commit cycle is >t is not visible to that RD. RD at t == commit cycle of an earlier WR to the same index returns the old data (read-before-write).
- Protocol errors: each raises err_pulse for 1 cycle and increments err_count, which saturates at 16'hFFFF.
  - ACT to an open bank: row is replaced.
  - RD/WR to a closed bank: RD returns valid with data 0; WR is dropped, no array write.
  - PRE to a closed bank.
- Multiple errors are impossible in one cycle (one command per cycle).
- Reset mid-operation: in-flight reads produce no valid; pending writes are discarded.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package (diram_phy_pkg): command encoding constants (CMD_PRE/ACT/RD/WR), command enum typedef, open-row entry struct.
- One natural sub-module, diram_phy_delay_pipe: parameterized valid+payload shift register. Instantiated for the RD return path (depth RL) and the WR index path (depth WL).

Test Plan:
- ACT bank3 row1; WR col5; drive data 0xA5..A5 at t+2; RD col5 -> valid=8'hFF exactly 4 cycles after the RD, data 0xA5..A5, err_count=0.
- RD bank7 with no ACT -> err_pulse at t+1, err_count=1, valid at t+4 with data 0.
- WR at t to idx X (new data 0x11), RD idx X at t+2 -> returns prior value 0x00. Repeat RD at t+3 -> returns 0x11.
- 8 back-to-back RDs cols 0..7 -> 8 consecutive valid cycles starting RL after the first, data in col order.
- ACT bank0 twice, then PRE bank0 twice -> err_count=2. Force 70000 errors -> err_count holds 16'hFFFF.
- Issue 3 RDs, assert reset_poweron=0 for 1 cycle at t+1 -> no valid ever appears, open-row table empty. A following RD errors; array data written before reset is still readable after a fresh ACT.

Source files
------------

// File: rtl/diram_phy_responder_pkg.sv
// Shared types for the DiRAM PHY responder: DFI command encoding and the
// per-bank open-row table entry.
package diram_phy_pkg;

    typedef enum logic [1:0] {
        CMD_PRE = 2'b00,
        CMD_ACT = 2'b01,
        CMD_RD  = 2'b10,
        CMD_WR  = 2'b11
    } cmd_e;

    // Row field is sized for the widest supported ROW_IDX_W; only the low
    // ROW_IDX_W bits are meaningful.
    localparam int ROW_IDX_MAX_W = 8;

    typedef struct packed {
        logic                     open;
        logic [ROW_IDX_MAX_W-1:0] row;
    } row_ent_t;

endpackage

// File: rtl/diram_phy_responder_if.sv
// DFI command/data bundle between a manager (master) and the PHY responder (slave).
interface diram_phy_if #(
    parameter int BANK_W = 5,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 256,
    parameter int GRP_W  = 8
);
    logic              dfi__phy__cs;
    logic              dfi__phy__cmd1;
    logic              dfi__phy__cmd0;
    logic [BANK_W-1:0] dfi__phy__bank;
    logic [ADDR_W-1:0] dfi__phy__addr;
    logic [DATA_W-1:0] dfi__phy__data;
    logic [GRP_W-1:0]  phy__dfi__valid;
    logic [DATA_W-1:0] phy__dfi__data;

    modport master (
        output dfi__phy__cs, dfi__phy__cmd1, dfi__phy__cmd0,
               dfi__phy__bank, dfi__phy__addr, dfi__phy__data,
        input  phy__dfi__valid, phy__dfi__data
    );

    modport slave (
        input  dfi__phy__cs, dfi__phy__cmd1, dfi__phy__cmd0,
               dfi__phy__bank, dfi__phy__addr, dfi__phy__data,
        output phy__dfi__valid, phy__dfi__data
    );
endinterface

// File: rtl/diram_phy_delay_pipe.sv
// Fixed-depth valid+payload shift register; output is the last stage register.
module diram_phy_delay_pipe #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vld_i,
    input  logic [W-1:0] pay_i,
    output logic         vld_o,
    output logic [W-1:0] pay_o
);
    logic [DEPTH-1:0]        vld_q;
    logic [DEPTH-1:0][W-1:0] pay_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            pay_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            pay_q[0] <= pay_i;
            for (int i = DEPTH - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1];
                pay_q[i] <= pay_q[i-1];
            end
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign pay_o = pay_q[DEPTH-1];
endmodule

// File: rtl/diram_phy_responder.sv
// DRAM-side DFI responder: open-row tracking, small backing array, fixed
// read/write latencies and a saturating protocol-error counter.
module diram_phy_responder
    import diram_phy_pkg::*;
#(
    parameter int BANK_W    = 5,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 256,
    parameter int GRP_W     = 8,
    parameter int ROW_IDX_W = 2,
    parameter int COL_IDX_W = 3,
    parameter int RL        = 4,
    parameter int WL        = 2
) (
    input  logic        clk,
    input  logic        reset_poweron,
    diram_phy_if.slave  dfi,
    output logic        err_pulse,
    output logic [15:0] err_count
);
    localparam int NBANK = 1 << BANK_W;
    localparam int IDX_W = BANK_W + ROW_IDX_W + COL_IDX_W;

    row_ent_t [NBANK-1:0] open_q;
    logic [DATA_W-1:0]    mem_q [2**IDX_W];
    logic                 err_pulse_q;
    logic [15:0]          err_count_q;

    cmd_e              cmd;
    logic [BANK_W-1:0] bank;
    logic [ADDR_W-1:0] addr;
    logic              bank_open, is_rd, is_wr, err_d;
    logic [IDX_W-1:0]  cmd_idx, wr_idx;
    logic [DATA_W-1:0] rd_pay;
    logic              rd_vld, wr_vld;
    logic              unused_bits;

    assign cmd       = cmd_e'({dfi.dfi__phy__cmd1, dfi.dfi__phy__cmd0});
    assign bank      = dfi.dfi__phy__bank;
    assign addr      = dfi.dfi__phy__addr;
    assign bank_open = open_q[bank].open;
    assign is_rd     = dfi.dfi__phy__cs && (cmd == CMD_RD);
    assign is_wr     = dfi.dfi__phy__cs && (cmd == CMD_WR);
    assign cmd_idx   = {bank, open_q[bank].row[ROW_IDX_W-1:0], addr[COL_IDX_W-1:0]};
    assign unused_bits = ^{addr, open_q};

    // ACT wants a closed bank; every other command wants it open.
    always_comb begin
        err_d = 1'b0;
        if (dfi.dfi__phy__cs)
            err_d = (cmd == CMD_ACT) ? bank_open : !bank_open;
    end

    // Closed-bank reads still return a beat, carrying zeros.
    assign rd_pay = (is_rd && bank_open) ? mem_q[cmd_idx] : '0;

    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            open_q <= '0;
        end else if (dfi.dfi__phy__cs) begin
            case (cmd)
                CMD_ACT: begin
                    open_q[bank].open <= 1'b1;
                    open_q[bank].row  <= ROW_IDX_MAX_W'(addr[ROW_IDX_W-1:0]);
                end
                CMD_PRE: open_q[bank].open <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= err_d;
            if (err_d && err_count_q != 16'hFFFF)
                err_count_q <= err_count_q + 16'd1;
        end
    end

    // Commit happens after the same-cycle read, giving read-before-write.
    always_ff @(posedge clk) begin
        if (reset_poweron && wr_vld)
            mem_q[wr_idx] <= dfi.dfi__phy__data;
    end

    diram_phy_delay_pipe #(.DEPTH(RL), .W(DATA_W)) u_rd_pipe (
        .clk   (clk),
        .rst_n (reset_poweron),
        .vld_i (is_rd),
        .pay_i (rd_pay),
        .vld_o (rd_vld),
        .pay_o (dfi.phy__dfi__data)
    );

    diram_phy_delay_pipe #(.DEPTH(WL), .W(IDX_W)) u_wr_pipe (
        .clk   (clk),
        .rst_n (reset_poweron),
        .vld_i (is_wr && bank_open),
        .pay_i (cmd_idx),
        .vld_o (wr_vld),
        .pay_o (wr_idx)
    );

    assign dfi.phy__dfi__valid = {GRP_W{rd_vld}};
    assign err_pulse           = err_pulse_q;
    assign err_count           = err_count_q;
endmodule

// File: tb/tb_diram_phy_responder.sv
// Bench for diram_phy_responder: directed vector table, hand sequences and a
// randomized run checked every cycle against a behavioural memory model.
module tb_diram_phy_responder;
    import diram_phy_pkg::*;

    localparam int BANK_W = 5, ADDR_W = 12, DATA_W = 256, GRP_W = 8;
    localparam int ROW_IDX_W = 2, COL_IDX_W = 3, RL = 4, WL = 2;
    localparam int NBANK = 1 << BANK_W;

    logic        clk = 1'b0;
    logic        reset_poweron;
    logic        err_pulse;
    logic [15:0] err_count;

    diram_phy_if #(.BANK_W(BANK_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GRP_W(GRP_W)) dfi ();

    diram_phy_responder #(
        .BANK_W(BANK_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GRP_W(GRP_W),
        .ROW_IDX_W(ROW_IDX_W), .COL_IDX_W(COL_IDX_W), .RL(RL), .WL(WL)
    ) dut (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .dfi           (dfi),
        .err_pulse     (err_pulse),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Behavioural model: bank state, sparse memory, expected returns by cycle.
    bit                m_open [NBANK];
    int                m_row  [NBANK];
    logic [DATA_W-1:0] m_mem  [int];
    int                pw     [int];
    bit                rv     [int];
    bit                rk     [int];
    logic [DATA_W-1:0] rd     [int];
    int                m_cnt;
    bit                m_err;

    typedef struct {
        int                cs, cmd, bank, addr;
        logic [DATA_W-1:0] wd;
        logic [GRP_W-1:0]  ev;
        logic [DATA_W-1:0] ed;
        logic              ep;
        logic [15:0]       ec;
    } vec_t;

    vec_t tbl [25];

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(int cs, int cmd, int bank, int addr, logic [DATA_W-1:0] wd,
                                int ev, logic [DATA_W-1:0] ed, int ep, int ec);
        vec_t r;
        r.cs = cs; r.cmd = cmd; r.bank = bank; r.addr = addr; r.wd = wd;
        r.ev = GRP_W'(ev); r.ed = ed; r.ep = 1'(ep); r.ec = 16'(ec);
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] pat(int c);
        logic [7:0] b;
        b = 8'(8'h30 + c);
        return {(DATA_W/8){b}};
    endfunction

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic do_cycle(input int rst_n, input int cs, input int cmd, input int bank,
                            input int addr, input logic [DATA_W-1:0] wd);
        int idx;
        bit err, open, expv;
        reset_poweron      = 1'(rst_n);
        dfi.dfi__phy__cs   = 1'(cs);
        dfi.dfi__phy__cmd1 = 1'(cmd >> 1);
        dfi.dfi__phy__cmd0 = 1'(cmd);
        dfi.dfi__phy__bank = BANK_W'(bank);
        dfi.dfi__phy__addr = ADDR_W'(addr);
        dfi.dfi__phy__data = wd;
        err  = 0;
        open = m_open[bank];
        if (rst_n == 0) begin
            foreach (m_open[i]) m_open[i] = 0;
            pw.delete(); rv.delete(); rk.delete(); rd.delete();
            m_cnt = 0;
        end else begin
            idx = (bank << (ROW_IDX_W + COL_IDX_W)) + (m_row[bank] << COL_IDX_W)
                + (addr % (1 << COL_IDX_W));
            if (cs != 0) begin
                case (cmd)
                    0: begin err = !open; m_open[bank] = 0; end
                    1: begin err = open; m_open[bank] = 1; m_row[bank] = addr % (1 << ROW_IDX_W); end
                    2: begin
                        err = !open;
                        rv[cyc+RL] = 1;
                        rk[cyc+RL] = 1;
                        rd[cyc+RL] = '0;
                        if (open) begin
                            if (m_mem.exists(idx)) rd[cyc+RL] = m_mem[idx];
                            else rk[cyc+RL] = 0;
                        end
                    end
                    default: begin err = !open; if (open) pw[cyc+WL] = idx; end
                endcase
            end
            if (pw.exists(cyc)) begin
                m_mem[pw[cyc]] = wd;
                pw.delete(cyc);
            end
            if (err && m_cnt < 65535) m_cnt++;
        end
        m_err = err;
        @(posedge clk);
        #1;
        cyc++;
        expv = rv.exists(cyc);
        chk("valid", DATA_W'(dfi.phy__dfi__valid), expv ? DATA_W'({GRP_W{1'b1}}) : '0);
        if (expv && rk[cyc]) chk("rdata", dfi.phy__dfi__data, rd[cyc]);
        chk("err_pulse", DATA_W'(err_pulse), DATA_W'(m_err));
        chk("err_count", DATA_W'(err_count), DATA_W'(m_cnt));
        if (expv) begin rv.delete(cyc); rk.delete(cyc); rd.delete(cyc); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] A5, H11, Z;
        bit expv;
        A5  = {(DATA_W/8){8'hA5}};
        H11 = {(DATA_W/8){8'h11}};
        Z   = '0;
        foreach (m_open[i]) begin m_open[i] = 0; m_row[i] = 0; end
        m_cnt = 0;
        m_err = 0;

        do_cycle(0, 0, 0, 0, 0, Z);
        do_cycle(0, 0, 0, 0, 0, Z);
        chk("rst_data", dfi.phy__dfi__data, '0);

        // ACT/WR/RD, closed-bank RD, read-before-write ordering
        tbl[0]  = mk(1, CMD_ACT, 3, 1, Z,   0,   Z,   0, 0);
        tbl[1]  = mk(1, CMD_WR,  3, 5, Z,   0,   Z,   0, 0);
        tbl[2]  = mk(0, 0,       0, 0, Z,   0,   Z,   0, 0);
        tbl[3]  = mk(0, 0,       0, 0, A5,  0,   Z,   0, 0);
        tbl[4]  = mk(1, CMD_RD,  3, 5, Z,   0,   Z,   0, 0);
        tbl[5]  = mk(0, 0,       0, 0, Z,   0,   Z,   0, 0);
        tbl[6]  = mk(0, 0,       0, 0, Z,   0,   Z,   0, 0);
        tbl[7]  = mk(0, 0,       0, 0, Z,   255, A5,  0, 0);
        tbl[8]  = mk(0, 0,       0, 0, Z,   0,   Z,   0, 0);
        tbl[9]  = mk(1, CMD_RD,  7, 0, Z,   0,   Z,   1, 1);
        tbl[10] = mk(0, 0,       0, 0, Z,   0,   Z,   0, 1);
        tbl[11] = mk(0, 0,       0, 0, Z,   0,   Z,   0, 1);
        tbl[12] = mk(0, 0,       0, 0, Z,   255, Z,   0, 1);
        tbl[13] = mk(0, 0,       0, 0, Z,   0,   Z,   0, 1);
        tbl[14] = mk(1, CMD_WR,  3, 2, Z,   0,   Z,   0, 1);
        tbl[15] = mk(0, 0,       0, 0, Z,   0,   Z,   0, 1);
        tbl[16] = mk(0, 0,       0, 0, Z,   0,   Z,   0, 1);
        tbl[17] = mk(1, CMD_WR,  3, 2, Z,   0,   Z,   0, 1);
        tbl[18] = mk(0, 0,       0, 0, Z,   0,   Z,   0, 1);
        tbl[19] = mk(1, CMD_RD,  3, 2, H11, 0,   Z,   0, 1);
        tbl[20] = mk(1, CMD_RD,  3, 2, Z,   0,   Z,   0, 1);
        tbl[21] = mk(0, 0,       0, 0, Z,   0,   Z,   0, 1);
        tbl[22] = mk(0, 0,       0, 0, Z,   255, Z,   0, 1);
        tbl[23] = mk(0, 0,       0, 0, Z,   255, H11, 0, 1);
        tbl[24] = mk(0, 0,       0, 0, Z,   0,   Z,   0, 1);
        for (int i = 0; i < 25; i++) begin
            do_cycle(1, tbl[i].cs, tbl[i].cmd, tbl[i].bank, tbl[i].addr, tbl[i].wd);
            chk($sformatf("vec%0d_valid", i), DATA_W'(dfi.phy__dfi__valid), DATA_W'(tbl[i].ev));
            chk($sformatf("vec%0d_pulse", i), DATA_W'(err_pulse), DATA_W'(tbl[i].ep));
            chk($sformatf("vec%0d_count", i), DATA_W'(err_count), DATA_W'(tbl[i].ec));
            if (tbl[i].ev != 0) chk($sformatf("vec%0d_data", i), dfi.phy__dfi__data, tbl[i].ed);
        end

        // Eight back-to-back reads of freshly written columns 0..7
        for (int i = 0; i < 8 + WL; i++)
            do_cycle(1, (i < 8) ? 1 : 0, CMD_WR, 3, i, (i >= WL) ? pat(i - WL) : Z);
        for (int k = 0; k < RL + 8; k++) begin
            do_cycle(1, (k < 8) ? 1 : 0, CMD_RD, 3, k, Z);
            expv = (k + 1 >= RL) && (k + 1 < RL + 8);
            chk("b2b_valid", DATA_W'(dfi.phy__dfi__valid), expv ? DATA_W'({GRP_W{1'b1}}) : '0);
            if (expv) chk("b2b_data", dfi.phy__dfi__data, pat(k + 1 - RL));
        end

        // Reset while reads are in flight
        for (int c = 0; c < 3; c++) do_cycle(1, 1, CMD_RD, 3, c, Z);
        do_cycle(0, 0, 0, 0, 0, Z);
        for (int i = 0; i < 8; i++) begin
            do_cycle(1, 0, 0, 0, 0, Z);
            chk("no_vld_after_rst", DATA_W'(dfi.phy__dfi__valid), '0);
        end
        do_cycle(1, 1, CMD_RD, 3, 0, Z);
        chk("rd_closed_after_rst_pulse", DATA_W'(err_pulse), DATA_W'(1));
        chk("rd_closed_after_rst_count", DATA_W'(err_count), DATA_W'(1));
        do_cycle(1, 1, CMD_ACT, 3, 1, Z);
        do_cycle(1, 1, CMD_RD, 3, 5, Z);
        for (int i = 0; i < RL - 1; i++) do_cycle(1, 0, 0, 0, 0, Z);
        chk("keep_mem_valid", DATA_W'(dfi.phy__dfi__valid), DATA_W'({GRP_W{1'b1}}));
        chk("keep_mem_data", dfi.phy__dfi__data, pat(5));

        // Double ACT and double PRE on bank 0
        do_cycle(1, 1, CMD_ACT, 0, 0, Z);
        do_cycle(1, 1, CMD_ACT, 0, 0, Z);
        do_cycle(1, 1, CMD_PRE, 0, 0, Z);
        do_cycle(1, 1, CMD_PRE, 0, 0, Z);
        chk("dbl_act_pre_count", DATA_W'(err_count), DATA_W'(3));
        chk("dbl_pre_pulse", DATA_W'(err_pulse), DATA_W'(1));

        // Randomized traffic on a few banks, with occasional resets
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0)
                do_cycle(0, 0, 0, 0, 0, Z);
            else
                do_cycle(1, ($urandom_range(0, 7) != 0) ? 1 : 0, int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)), rnd_data());
        end

        // Counter saturation
        for (int n = 0; n < 66000; n++) do_cycle(1, 1, CMD_PRE, 1, 0, Z);
        chk("sat_count", DATA_W'(err_count), DATA_W'(16'hFFFF));
        do_cycle(1, 1, CMD_PRE, 1, 0, Z);
        chk("sat_hold", DATA_W'(err_count), DATA_W'(16'hFFFF));
        chk("sat_pulse", DATA_W'(err_pulse), DATA_W'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
